// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants for the register-file writeback queue.
// The regfile has 8 registers, hence a 3-bit select.
package regfile_wb_queue_pkg;
  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int WIDTH_DEF = 16;
endpackage

// File: rtl/wbq_fwd_lookup.sv
// Forwarding lookup for one read select.
// Reports the youngest valid queue entry that targets the select.
module wbq_fwd_lookup
  import regfile_wb_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][REG_SEL_W-1:0] ent_reg,
  input  logic [DEPTH-1:0][WIDTH-1:0]     ent_data,
  input  logic [DEPTH-1:0]                ent_vld,
  input  logic [$clog2(DEPTH)-1:0]        tail,
  input  logic [REG_SEL_W-1:0]            sel,
  output logic                            hit,
  output logic [WIDTH-1:0]                data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PW'(k + 1);
      if (ent_vld[idx] && (ent_reg[idx] == sel)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO feeding the regfile's single write port,
// with forwarding of pending values to both read selects.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [REG_SEL_W-1:0]       in_reg,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       hold,
  output logic [REG_SEL_W-1:0]       writeRegSel,
  output logic [WIDTH-1:0]           writeData,
  output logic                       writeEn,
  input  logic [REG_SEL_W-1:0]       read1RegSel,
  input  logic [REG_SEL_W-1:0]       read2RegSel,
  output logic                       fwd1Hit,
  output logic [WIDTH-1:0]           fwd1Data,
  output logic                       fwd2Hit,
  output logic [WIDTH-1:0]           fwd2Data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][REG_SEL_W-1:0] ent_reg;
  logic [DEPTH-1:0][WIDTH-1:0]     ent_data;
  logic [DEPTH-1:0]                ent_vld;
  logic [PW-1:0]                   head, tail;
  logic [CW-1:0]                   cnt;
  logic                            full, empty, pop, push;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Gating with rst keeps the regfile from capturing anything in a reset cycle.
  assign pop      = rst & !empty & !hold;
  assign in_ready = !full | pop;
  assign push     = in_valid & in_ready;

  assign writeEn     = pop;
  assign writeRegSel = empty ? '0 : ent_reg[head];
  assign writeData   = empty ? '0 : ent_data[head];
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        head          <= head + PW'(1);
        ent_vld[head] <= 1'b0;
      end
      // When full, head==tail: the push must win over the pop's clear.
      if (push) begin
        tail          <= tail + PW'(1);
        ent_vld[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset; validity is tracked by ent_vld.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ent_reg[tail]  <= in_reg;
      ent_data[tail] <= in_data;
    end
  end

  logic [1:0][REG_SEL_W-1:0] rsel;
  logic [1:0]                fhit;
  logic [1:0][WIDTH-1:0]     fdata;

  assign rsel = {read2RegSel, read1RegSel};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    wbq_fwd_lookup #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fwd (
      .ent_reg  (ent_reg),
      .ent_data (ent_data),
      .ent_vld  (ent_vld),
      .tail     (tail),
      .sel      (rsel[g]),
      .hit      (fhit[g]),
      .data     (fdata[g])
    );
  end

  assign fwd1Hit  = fhit[0];
  assign fwd1Data = fdata[0];
  assign fwd2Hit  = fhit[1];
  assign fwd2Data = fdata[1];

  assign err = ((^{clk, rst, in_valid, in_reg, in_data, hold, read1RegSel, read2RegSel}) === 1'bx)
             || (cnt > CW'(DEPTH));
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_queue;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [2:0]       in_reg;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             hold;
  logic [2:0]       writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             writeEn;
  logic [2:0]       read1RegSel, read2RegSel;
  logic             fwd1Hit, fwd2Hit;
  logic [WIDTH-1:0] fwd1Data, fwd2Data;
  logic [2:0]       count;
  logic             err;

  regfile_wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .hold(hold), .writeRegSel(writeRegSel), .writeData(writeData),
    .writeEn(writeEn), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .fwd1Hit(fwd1Hit), .fwd1Data(fwd1Data), .fwd2Hit(fwd2Hit), .fwd2Data(fwd2Data),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] r; logic [WIDTH-1:0] d; } wr_t;

  wr_t              q[$];
  logic [WIDTH-1:0] mrf[8];
  logic [WIDTH-1:0] trf[8];
  int               checks = 0;
  int               errors = 0;
  bit               chk_on = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile fed by the DUT's write port.
  always @(posedge clk) if (writeEn) trf[writeRegSel] <= writeData;

  // Reference model: a plain FIFO of pending writes and a model regfile.
  always @(posedge clk) begin
    bit do_pop, rdy;
    if (!rst) q.delete();
    else begin
      do_pop = (q.size() > 0) && !hold;
      rdy    = (q.size() < DEPTH) || do_pop;
      if (do_pop) begin
        mrf[q[0].r] = q[0].d;
        void'(q.pop_front());
      end
      if (in_valid && rdy) q.push_back('{r: in_reg, d: in_data});
    end
  end

  always @(negedge clk) begin
    bit exp_we, h1, h2;
    logic [WIDTH-1:0] d1, d2;
    if (chk_on) begin
      exp_we = rst && (q.size() > 0) && !hold;
      h1 = 0; h2 = 0; d1 = '0; d2 = '0;
      foreach (q[i]) begin
        if (q[i].r == read1RegSel) begin h1 = 1; d1 = q[i].d; end
        if (q[i].r == read2RegSel) begin h2 = 1; d2 = q[i].d; end
      end
      cmp("count", int'(count), q.size());
      cmp("writeEn", int'(writeEn), int'(exp_we));
      cmp("in_ready", int'(in_ready), int'((q.size() < DEPTH) || exp_we));
      cmp("fwd1Hit", int'(fwd1Hit), int'(h1));
      cmp("fwd2Hit", int'(fwd2Hit), int'(h2));
      cmp("err", int'(err), 0);
      if (exp_we) begin
        cmp("writeRegSel", int'(writeRegSel), int'(q[0].r));
        cmp("writeData", int'(writeData), int'(q[0].d));
      end
      if (h1) cmp("fwd1Data", int'(fwd1Data), int'(d1));
      if (h2) cmp("fwd2Data", int'(fwd2Data), int'(d2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_reg = r; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mrf[i] = '0; trf[i] = '0; end
    rst = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; hold = 1'b0;
    read1RegSel = 3'd0; read2RegSel = 3'd0;

    // Reset then idle
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    cmp("rst_writeEn", int'(writeEn), 0);
    cmp("rst_count", int'(count), 0);
    cmp("rst_in_ready", int'(in_ready), 1);
    cmp("rst_fwd1Hit", int'(fwd1Hit), 0);
    cmp("rst_fwd2Hit", int'(fwd2Hit), 0);
    cmp("rst_err", int'(err), 0);
    tick();

    // Single write
    push(3'd3, 16'hBEEF);
    cmp("single_we", int'(writeEn), 1);
    cmp("single_sel", int'(writeRegSel), 3);
    cmp("single_data", int'(writeData), 16'hBEEF);
    tick();
    cmp("single_count", int'(count), 0);
    cmp("single_rf3", int'(trf[3]), 16'hBEEF);
    cmp("model_rf3", int'(mrf[3]), 16'hBEEF);

    // Fill and backpressure
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(3'(i), 16'h1000 + 16'(i));
    cmp("fill_count", int'(count), 4);
    cmp("fill_ready", int'(in_ready), 0);
    push(3'd7, 16'h7777);
    cmp("fill_count5", int'(count), 4);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      cmp("drain_we", int'(writeEn), 1);
      cmp("drain_sel", int'(writeRegSel), i);
      cmp("drain_data", int'(writeData), 16'h1000 + i);
      tick();
    end
    cmp("drain_count", int'(count), 0);
    cmp("drain_rf4", int'(trf[4]), 16'h1004);
    cmp("drain_rf7", int'(trf[7]), 0);

    // Full with simultaneous push/pop
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(3'(i), 16'h2000 + 16'(i));
    hold = 1'b0;
    in_valid = 1'b1; in_reg = 3'd5; in_data = 16'h0055;
    #1;
    cmp("full_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    cmp("full_count", int'(count), 4);
    tick(); tick(); tick();
    cmp("full_last_sel", int'(writeRegSel), 5);
    cmp("full_last_data", int'(writeData), 16'h0055);
    tick();
    cmp("full_empty", int'(count), 0);
    cmp("full_rf5", int'(trf[5]), 16'h0055);

    // Forwarding youngest-wins
    hold = 1'b1;
    read1RegSel = 3'd2; read2RegSel = 3'd6;
    push(3'd2, 16'h1111);
    push(3'd2, 16'h2222);
    cmp("fwd1_hit", int'(fwd1Hit), 1);
    cmp("fwd1_data", int'(fwd1Data), 16'h2222);
    cmp("fwd2_hit", int'(fwd2Hit), 0);
    hold = 1'b0;
    tick(); tick();
    cmp("fwd1_after", int'(fwd1Hit), 0);
    cmp("fwd_rf2", int'(trf[2]), 16'h2222);
    cmp("model_rf2", int'(mrf[2]), 16'h2222);

    // Reset mid-operation
    hold = 1'b1;
    push(3'd5, 16'hAAAA);
    push(3'd6, 16'hBBBB);
    push(3'd7, 16'hCCCC);
    hold = 1'b0;
    rst = 1'b0;
    #1;
    cmp("midrst_we", int'(writeEn), 0);
    tick();
    rst = 1'b1;
    #1;
    cmp("midrst_count", int'(count), 0);
    cmp("midrst_we2", int'(writeEn), 0);
    tick(); tick();
    cmp("midrst_rf5", int'(trf[5]), 16'h0055);
    cmp("midrst_rf6", int'(trf[6]), 0);
    cmp("midrst_rf7", int'(trf[7]), 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
